// File: rtl/instr_issue_unit_if.sv
// Bus between the instruction issue unit, instruction memory and the control unit.
// master = issue unit side, slave = memory/control environment side.
interface instr_issue_unit_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [5:0]        op_code;
   logic [5:0]        func_code;
   logic [15:0]       imm16;
   logic              issue_valid;
   logic              branch;
   logic              alu_zero;
   logic              pc_we;
   logic              mem_done;

   modport master (
      output imem_addr, op_code, func_code, imm16, issue_valid,
      input  imem_rdata, branch, alu_zero, pc_we, mem_done
   );

   modport slave (
      input  imem_addr, op_code, func_code, imm16, issue_valid,
      output imem_rdata, branch, alu_zero, pc_we, mem_done
   );
endinterface

// File: rtl/instr_issue_unit.sv
// Instruction fetch/issue sequencer: FETCH -> WAIT_RD -> ISSUE, with MEM_WAIT and HALT.
// Optional MEM_WAIT timeout fault is built only when ISSUE_TIMEOUT_EN is defined.
module instr_issue_unit #(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_issue_unit_if.master  bus,
   output logic                halted,
   output logic [15:0]         instr_count,
   output logic                fault
);
   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_WAIT_RD  = 3'd1,
      S_ISSUE    = 3'd2,
      S_MEM_WAIT = 3'd3,
      S_HALT     = 3'd4
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] pc_reg;
   logic [5:0]        op_reg;
   logic [5:0]        func_reg;
   logic [15:0]       imm_reg;
   logic              halted_reg;
   logic [15:0]       count_reg;

   logic              halt_op;
   logic              timeout_hit;
   logic              issue_valid_c;
   logic              load_instr;
   logic              pc_advance;
   logic              take_branch;
   logic              retire;
   logic              set_halt;
   logic              set_fault;
   logic [ADDR_W-1:0] imm_sext;
   logic [ADDR_W-1:0] pc_plus1;
   logic [ADDR_W-1:0] branch_target;

   assign halt_op = (op_reg == 6'h3F);

   // Sign-extend (or truncate) imm16 to the PC width so the target wraps like the PC.
   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_sext
         if (gi < 16) begin : g_low
            assign imm_sext[gi] = imm_reg[gi];
         end else begin : g_high
            assign imm_sext[gi] = imm_reg[15];
         end
      end
   endgenerate

   assign pc_plus1      = pc_reg + ADDR_W'(1);
   assign branch_target = pc_plus1 + imm_sext;

`ifdef ISSUE_TIMEOUT_EN
   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wait_cnt_reg;
   logic       fault_reg;

   assign timeout_hit = (wait_cnt_reg == WAIT_LIMIT);

   // Counter is zeroed in ISSUE so it always starts from 0 on MEM_WAIT entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_reg <= 8'd0;
         fault_reg    <= 1'b0;
      end else begin
         if (state_reg == S_ISSUE) begin
            wait_cnt_reg <= 8'd0;
         end else if (state_reg == S_MEM_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
         end
         if (set_fault) begin
            fault_reg <= 1'b1;
         end
      end
   end

   assign fault = fault_reg;
`else
   assign timeout_hit = 1'b0;
   assign fault       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:   state_next = S_WAIT_RD;
         S_WAIT_RD: state_next = S_ISSUE;
         S_ISSUE: begin
            if (halt_op) begin
               state_next = S_HALT;
            end else if (bus.pc_we) begin
               state_next = S_FETCH;
            end else begin
               state_next = S_MEM_WAIT;
            end
         end
         S_MEM_WAIT: begin
            // A completion arriving on the limit cycle still retires normally.
            if (bus.mem_done) begin
               state_next = S_FETCH;
            end else if (timeout_hit) begin
               state_next = S_HALT;
            end
         end
         S_HALT:    state_next = S_HALT;
         default:   state_next = S_FETCH;
      endcase
   end

   always_comb begin
      issue_valid_c = 1'b0;
      load_instr    = 1'b0;
      pc_advance    = 1'b0;
      take_branch   = 1'b0;
      retire        = 1'b0;
      set_halt      = 1'b0;
      set_fault     = 1'b0;
      case (state_reg)
         S_WAIT_RD: load_instr = 1'b1;
         S_ISSUE: begin
            issue_valid_c = 1'b1;
            if (halt_op) begin
               retire   = 1'b1;
               set_halt = 1'b1;
            end else if (bus.pc_we) begin
               retire      = 1'b1;
               pc_advance  = 1'b1;
               take_branch = bus.branch & bus.alu_zero;
            end
         end
         S_MEM_WAIT: begin
            if (bus.mem_done) begin
               retire     = 1'b1;
               pc_advance = 1'b1;
            end else if (timeout_hit) begin
               set_fault = 1'b1;
               set_halt  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg     <= '0;
         op_reg     <= 6'd0;
         func_reg   <= 6'd0;
         imm_reg    <= 16'd0;
         halted_reg <= 1'b0;
         count_reg  <= 16'd0;
      end else begin
         if (load_instr) begin
            op_reg   <= bus.imem_rdata[31:26];
            func_reg <= bus.imem_rdata[5:0];
            imm_reg  <= bus.imem_rdata[15:0];
         end
         if (pc_advance) begin
            pc_reg <= take_branch ? branch_target : pc_plus1;
         end
         if (retire) begin
            count_reg <= count_reg + 16'd1;
         end
         if (set_halt) begin
            halted_reg <= 1'b1;
         end
      end
   end

   assign bus.imem_addr   = pc_reg;
   assign bus.op_code     = op_reg;
   assign bus.func_code   = func_reg;
   assign bus.imm16       = imm_reg;
   assign bus.issue_valid = issue_valid_c;
   assign halted          = halted_reg;
   assign instr_count     = count_reg;
endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: stimulus queues expected issues, a negedge
// monitor pops and compares them whenever issue_valid is seen.
module tb_instr_issue_unit;
   localparam int ADDR_W         = 8;
   localparam int TIMEOUT_CYCLES = 16;

   localparam logic [31:0] W_NOP    = 32'h0000_0020;
   localparam logic [31:0] W_LW     = 32'h8C00_0010;
   localparam logic [31:0] W_LW_NEG = 32'h8C00_FFFC;
   localparam logic [31:0] W_BEQ_A  = 32'h1000_000A;
   localparam logic [31:0] W_BEQ_M4 = 32'h1000_FFFC;
   localparam logic [31:0] W_BEQ_EB = 32'h1000_00EB;
   localparam logic [31:0] W_BEQ_M3 = 32'h1000_FFFD;
   localparam logic [31:0] W_BEQ_3  = 32'h1000_0003;
   localparam logic [31:0] W_HALT   = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        halted;
   logic [15:0] instr_count;
   logic        fault;

   instr_issue_unit_if #(.ADDR_W(ADDR_W)) bus ();

   instr_issue_unit #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .halted(halted),
      .instr_count(instr_count),
      .fault(fault)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [256];

   // Synchronous instruction memory: word appears one cycle after the address.
   always @(posedge clk) begin
      bus.imem_rdata <= imem[bus.imem_addr];
   end

   typedef struct {
      logic [7:0]  pc;
      logic [5:0]  op;
      logic [5:0]  func;
      logic [15:0] imm;
      logic [15:0] count;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.issue_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue actual=issue at pc %h required=no issue", bus.imem_addr);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.imem_addr !== mon_e.pc || bus.op_code !== mon_e.op ||
                bus.func_code !== mon_e.func || bus.imm16 !== mon_e.imm ||
                instr_count !== mon_e.count) begin
               errors++;
               $display("FAIL issue actual=pc %h op %h func %h imm %h cnt %0d required=pc %h op %h func %h imm %h cnt %0d",
                        bus.imem_addr, bus.op_code, bus.func_code, bus.imm16, instr_count,
                        mon_e.pc, mon_e.op, mon_e.func, mon_e.imm, mon_e.count);
            end else begin
               $display("issue pc=%h op=%h func=%h imm=%h cnt=%0d ok",
                        bus.imem_addr, bus.op_code, bus.func_code, bus.imm16, instr_count);
            end
         end
      end
   end

   // Runs one instruction starting from the FETCH cycle; delay>0 pulses mem_done
   // in that MEM_WAIT cycle, delay==0 leaves a memory op waiting.
   task automatic do_instr(input logic [7:0] pc, input logic [31:0] word,
                           input logic br, input logic z, input logic pwe,
                           input int delay, input logic early_done, input logic chk_lat);
      int   n;
      exp_t e;
      logic is_halt;
      is_halt      = (word[31:26] == 6'h3F);
      imem[pc]     = word;
      bus.branch   = br;
      bus.alu_zero = z;
      bus.pc_we    = pwe;
      e.pc    = pc;
      e.op    = word[31:26];
      e.func  = word[5:0];
      e.imm   = word[15:0];
      e.count = exp_count;
      exp_q.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.issue_valid !== 1'b1 && n < 20);
      if (bus.issue_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout actual=no issue in %0d cycles required=issue at pc %h", n, pc);
         finish_run();
      end
      if (chk_lat) check("issue_latency", n, 3);
      if (early_done) bus.mem_done = 1'b1;
      if (is_halt || pwe) exp_count = exp_count + 16'd1;
      @(posedge clk);
      #1;
      bus.mem_done = 1'b0;
      if (!is_halt && !pwe && delay > 0) begin
         repeat (delay - 1) begin
            @(posedge clk);
            #1;
         end
         check("memwait_addr_held", bus.imem_addr, pc);
         check("memwait_count_held", instr_count, exp_count);
         bus.mem_done = 1'b1;
         @(posedge clk);
         #1;
         bus.mem_done = 1'b0;
         exp_count = exp_count + 16'd1;
      end
      check("instr_count", instr_count, exp_count);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = W_NOP;
      rst_n        = 1'b0;
      bus.branch   = 1'b0;
      bus.alu_zero = 1'b0;
      bus.pc_we    = 1'b1;
      bus.mem_done = 1'b0;
      exp_count    = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_imem_addr", bus.imem_addr, 0);
      check("rst_op_code", bus.op_code, 0);
      check("rst_func_code", bus.func_code, 0);
      check("rst_imm16", bus.imm16, 0);
      check("rst_issue_valid", bus.issue_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_instr_count", instr_count, 0);
      check("rst_fault", fault, 0);
      rst_n = 1'b1;

      // Sequential issue, then a memory op with an ignored done in its ISSUE cycle.
      for (int p = 0; p < 4; p++) do_instr(8'(p), W_NOP, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'h04, W_LW, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
      check("count_after_5", instr_count, 16'd5);

      // Branches: forward to 0x10, back to 0x0D, then not-taken at 0x10.
      do_instr(8'h05, W_BEQ_A,  1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'h10, W_BEQ_M4, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'h0D, W_NOP,    1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'h0E, W_NOP,    1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'h0F, W_NOP,    1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'h10, W_BEQ_M4, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      // Memory op with branch/zero high must still go to pc+1.
      do_instr(8'h11, W_LW_NEG, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1);

      // Wrap-around: reach 0xFE, step through 0xFF -> 0x00, back to 0xFE, branch to 0x02.
      do_instr(8'h12, W_BEQ_EB, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'hFE, W_BEQ_3,  1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'hFF, W_NOP,    1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'h00, W_BEQ_M3, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      do_instr(8'hFE, W_BEQ_3,  1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      for (int p = 2; p < 7; p++) do_instr(8'(p), W_NOP, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

      // Halt at pc 7; inputs that would otherwise branch or stall are ignored.
      do_instr(8'h07, W_HALT, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      check("halt_halted", halted, 1);
      check("halt_addr", bus.imem_addr, 8'h07);
      repeat (8) begin
         @(posedge clk);
         #1;
         bus.mem_done = ~bus.mem_done;
         bus.pc_we    = ~bus.pc_we;
      end
      bus.mem_done = 1'b0;
      check("halt_addr_stays", bus.imem_addr, 8'h07);
      check("halt_count_stays", instr_count, exp_count);
      check("halt_op_stays", bus.op_code, 6'h3F);
      check("halt_sticky", halted, 1);

      // Reset pulse out of HALT acts asynchronously.
      rst_n = 1'b0;
      #1;
      check("rst2_addr", bus.imem_addr, 0);
      check("rst2_halted", halted, 0);
      check("rst2_count", instr_count, 0);
      exp_count = 16'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_instr(8'h00, W_NOP, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

      // Reset while in MEM_WAIT with a simultaneous mem_done.
      do_instr(8'h01, W_LW, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.mem_done = 1'b1;
      rst_n        = 1'b0;
      #1;
      check("rst3_addr", bus.imem_addr, 0);
      check("rst3_op", bus.op_code, 0);
      check("rst3_func", bus.func_code, 0);
      check("rst3_imm", bus.imm16, 0);
      check("rst3_count", instr_count, 0);
      check("rst3_issue_valid", bus.issue_valid, 0);
      check("rst3_fault", fault, 0);
      exp_count = 16'd0;
      @(posedge clk);
      #1;
      bus.mem_done = 1'b0;
      rst_n        = 1'b1;
      do_instr(8'h00, W_NOP, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

      // Long memory wait.
      do_instr(8'h01, W_LW, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
`ifdef ISSUE_TIMEOUT_EN
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      bus.mem_done = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_done = 1'b0;
      exp_count = exp_count + 16'd1;
      check("limit_done_fault", fault, 0);
      check("limit_done_halted", halted, 0);
      check("limit_done_count", instr_count, exp_count);
      do_instr(8'h02, W_LW, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      check("timeout_not_yet", fault, 0);
      @(posedge clk);
      #1;
      check("timeout_fault", fault, 1);
      check("timeout_halted", halted, 1);
      check("timeout_count", instr_count, exp_count);
      check("timeout_addr", bus.imem_addr, 8'h02);
`else
      repeat (24) begin
         @(posedge clk);
         #1;
      end
      check("wait_fault", fault, 0);
      check("wait_halted", halted, 0);
      check("wait_addr", bus.imem_addr, 8'h01);
      check("wait_count", instr_count, exp_count);
      bus.mem_done = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_done = 1'b0;
      exp_count = exp_count + 16'd1;
      check("wait_retire_count", instr_count, exp_count);
      do_instr(8'h02, W_NOP, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
`endif
      check("scoreboard_empty", exp_q.size(), 0);
      finish_run();
   end
endmodule
